// File: rtl/mips_decode_stage_pkg.sv
// Shared encodings for the MIPS decode stage: opcode/funct values, ALU op codes,
// second-operand source selects, the control bundle and the stage state type.
package mips_decode_stage_pkg;

   localparam logic [5:0] OP_OTHER0 = 6'h00;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ANDI   = 6'h0c;
   localparam logic [5:0] OP_ORI    = 6'h0d;
   localparam logic [5:0] OP_XORI   = 6'h0e;

   localparam logic [5:0] OP0_ADD = 6'h20;
   localparam logic [5:0] OP0_SUB = 6'h22;
   localparam logic [5:0] OP0_AND = 6'h24;
   localparam logic [5:0] OP0_OR  = 6'h25;
   localparam logic [5:0] OP0_XOR = 6'h26;
   localparam logic [5:0] OP0_NOR = 6'h27;

   localparam logic [2:0] ALU_NONE = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b011;
   localparam logic [2:0] ALU_AND  = 3'b100;
   localparam logic [2:0] ALU_OR   = 3'b101;
   localparam logic [2:0] ALU_NOR  = 3'b110;
   localparam logic [2:0] ALU_XOR  = 3'b111;

   localparam logic [1:0] SRC2_REG  = 2'b00;
   localparam logic [1:0] SRC2_SEXT = 2'b01;
   localparam logic [1:0] SRC2_ZEXT = 2'b10;
   localparam logic [1:0] SRC2_BAD  = 2'b11;

   typedef struct packed {
      logic       rd_src;
      logic       writeenable;
      logic [1:0] alu_src2;
      logic [2:0] alu_op;
      logic       except;
   } ctrl_t;

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } state_t;

endpackage

// File: rtl/mips_decode_stage_core.sv
// Purely combinational decode of one instruction word into ALU/regfile control,
// destination register select and the extended immediate.
module mips_decode_core
   import mips_decode_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [31:0]           inst,
   output ctrl_t                 ctrl,
   output logic [4:0]            dest_num,
   output logic [DATA_WIDTH-1:0] imm_ext
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [15:0] imm;

   assign opcode = inst[31:26];
   assign funct  = inst[5:0];
   assign imm    = inst[15:0];

   always_comb begin
      ctrl.rd_src      = 1'b0;
      ctrl.writeenable = 1'b0;
      ctrl.alu_src2    = SRC2_BAD;
      ctrl.alu_op      = ALU_NONE;
      ctrl.except      = 1'b1;
      case (opcode)
         OP_OTHER0: begin
            // Unknown funct still reports a register-sourced operand.
            ctrl.alu_src2    = SRC2_REG;
            ctrl.writeenable = 1'b1;
            ctrl.except      = 1'b0;
            case (funct)
               OP0_ADD: ctrl.alu_op = ALU_ADD;
               OP0_SUB: ctrl.alu_op = ALU_SUB;
               OP0_AND: ctrl.alu_op = ALU_AND;
               OP0_OR:  ctrl.alu_op = ALU_OR;
               OP0_NOR: ctrl.alu_op = ALU_NOR;
               OP0_XOR: ctrl.alu_op = ALU_XOR;
               default: begin
                  ctrl.writeenable = 1'b0;
                  ctrl.except      = 1'b1;
               end
            endcase
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
            ctrl.rd_src      = 1'b1;
            ctrl.writeenable = 1'b1;
            ctrl.except      = 1'b0;
            ctrl.alu_src2    = (opcode == OP_ADDI) ? SRC2_SEXT : SRC2_ZEXT;
            case (opcode)
               OP_ADDI: ctrl.alu_op = ALU_ADD;
               OP_ANDI: ctrl.alu_op = ALU_AND;
               OP_ORI:  ctrl.alu_op = ALU_OR;
               default: ctrl.alu_op = ALU_XOR;
            endcase
         end
         default: ;
      endcase
   end

   assign dest_num = ctrl.rd_src ? inst[20:16] : inst[15:11];

   always_comb begin
      imm_ext = DATA_WIDTH'(imm);
      if (ctrl.alu_src2 == SRC2_SEXT) begin
         imm_ext = DATA_WIDTH'($signed(imm));
      end
   end

endmodule

// File: rtl/mips_decode_stage.sv
// Registered decode stage: valid/ready handshake, one-cycle output register,
// RUN/HALTED exception state machine and saturating exception counter.
module mips_decode_stage
   import mips_decode_stage_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int CNT_WIDTH      = 8,
   parameter int HALT_ON_EXCEPT = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           inst,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4:0]            rs_num,
   output logic [4:0]            rt_num,
   output logic [4:0]            dest_num,
   output logic [DATA_WIDTH-1:0] imm_ext,
   output logic                  rd_src,
   output logic                  writeenable,
   output logic [1:0]            alu_src2,
   output logic [2:0]            alu_op,
   output logic                  except,
   output logic                  halted,
   input  logic                  clear_except,
   output logic [CNT_WIDTH-1:0]  except_count
);

   localparam logic HALT_EN = (HALT_ON_EXCEPT != 0);

   ctrl_t                 dec_ctrl;
   logic [4:0]            dec_dest;
   logic [DATA_WIDTH-1:0] dec_imm;

   state_t                state_q, state_d;
   logic                  out_valid_q, out_valid_d;
   logic [4:0]            rs_q, rs_d;
   logic [4:0]            rt_q, rt_d;
   logic [4:0]            dest_q, dest_d;
   logic [DATA_WIDTH-1:0] imm_q, imm_d;
   ctrl_t                 ctrl_q, ctrl_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  accept;
   logic                  transfer;

   mips_decode_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .inst     (inst),
      .ctrl     (dec_ctrl),
      .dest_num (dec_dest),
      .imm_ext  (dec_imm)
   );

   assign halted   = (state_q == ST_HALTED);
   assign in_ready = (~out_valid_q | out_ready) & ~halted;
   assign accept   = in_valid & in_ready;
   assign transfer = out_valid_q & out_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      dest_d      = dest_q;
      imm_d       = imm_q;
      ctrl_d      = ctrl_q;
      if (accept) begin
         out_valid_d = 1'b1;
         rs_d        = inst[25:21];
         rt_d        = inst[20:16];
         dest_d      = dec_dest;
         imm_d       = dec_imm;
         ctrl_d      = dec_ctrl;
      end else if (transfer) begin
         out_valid_d = 1'b0;
      end
   end

   // Counts on the way out, so the held word's except bit is the one that matters.
   always_comb begin
      cnt_d = cnt_q;
      if (transfer && ctrl_q.except && !(&cnt_q)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // A newly accepted exception beats a simultaneous clear.
   always_comb begin
      state_d = state_q;
      if (accept && dec_ctrl.except && HALT_EN) begin
         state_d = ST_HALTED;
      end else if (state_q == ST_HALTED && clear_except) begin
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_RUN;
         out_valid_q <= 1'b0;
         rs_q        <= '0;
         rt_q        <= '0;
         dest_q      <= '0;
         imm_q       <= '0;
         ctrl_q      <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         dest_q      <= dest_d;
         imm_q       <= imm_d;
         ctrl_q      <= ctrl_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign rs_num       = rs_q;
   assign rt_num       = rt_q;
   assign dest_num     = dest_q;
   assign imm_ext      = imm_q;
   assign rd_src       = ctrl_q.rd_src;
   assign writeenable  = ctrl_q.writeenable;
   assign alu_src2     = ctrl_q.alu_src2;
   assign alu_op       = ctrl_q.alu_op;
   assign except       = ctrl_q.except;
   assign except_count = cnt_q;

endmodule
